// File: rtl/debug_scan_slave_mc_if.sv
// Signal bundle between a JTAG-style virtual TAP front end and the multi-channel scan slave.
// Request semantics: a take_action/take_no_action bit stays high until the consumer pulses ack.
interface debug_scan_slave_mc_if #(
    parameter int IR_W = 2,
    parameter int DR_W = 38
);
    localparam int NCH = 2 ** IR_W;

    logic [IR_W-1:0]     ir_in;
    logic                vs_uir;
    logic                vs_cdr;
    logic                vs_udr;
    logic                vs_sdr;
    logic                shift_en;
    logic                tdi;
    logic                tdo;
    logic [NCH*DR_W-1:0] cap_data;
    logic                ack;
    logic                clr_err;
    logic [IR_W-1:0]     ir_out;
    logic [DR_W-1:0]     jdo;
    logic [NCH-1:0]      take_action;
    logic [NCH-1:0]      take_no_action;
    logic                busy;
    logic                overrun;
    logic                short_scan;

    modport slave (
        input  ir_in, vs_uir, vs_cdr, vs_udr, vs_sdr, shift_en, tdi, cap_data, ack, clr_err,
        output tdo, ir_out, jdo, take_action, take_no_action, busy, overrun, short_scan
    );

    modport master (
        output ir_in, vs_uir, vs_cdr, vs_udr, vs_sdr, shift_en, tdi, cap_data, ack, clr_err,
        input  tdo, ir_out, jdo, take_action, take_no_action, busy, overrun, short_scan
    );
endinterface

// File: rtl/debug_scan_slave_mc.sv
// Multi-channel debug scan slave: IR-selected capture/shift register, update words
// turned into one-hot action requests held until acknowledged, with sticky error flags.
module debug_scan_slave_mc #(
    parameter int IR_W    = 2,
    parameter int DR_W    = 38,
    parameter int ACT_BIT = DR_W - 1
) (
    input logic clk,
    input logic reset,
    debug_scan_slave_mc_if.slave bus
);
    localparam int NCH = 2 ** IR_W;
    localparam int CW  = $clog2(DR_W + 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t          state;
    logic [IR_W-1:0] ir_q;
    logic [DR_W-1:0] sr;
    logic [CW-1:0]   cnt;
    logic [DR_W-1:0] jdo_q;
    logic [NCH-1:0]  act_q;
    logic [NCH-1:0]  noact_q;
    logic            ovr_q;
    logic            short_q;

    logic           free;
    logic           accept;
    logic           drop;
    logic           do_cap;
    logic           do_shift;
    logic [NCH-1:0] sel;

    // Strobe priority: update-IR blocks everything else, then update-DR, capture, shift.
    always_comb begin
        free     = (state == IDLE) || bus.ack;
        accept   = !bus.vs_uir && bus.vs_udr && free;
        drop     = !bus.vs_uir && bus.vs_udr && !free;
        do_cap   = !bus.vs_uir && !bus.vs_udr && bus.vs_cdr;
        do_shift = !bus.vs_uir && !bus.vs_udr && !bus.vs_cdr && bus.vs_sdr && bus.shift_en;
        sel      = NCH'(1) << ir_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ir_q    <= '0;
            sr      <= '0;
            cnt     <= '0;
            jdo_q   <= '0;
            act_q   <= '0;
            noact_q <= '0;
            ovr_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            if (state == PEND && bus.ack) begin
                state   <= IDLE;
                act_q   <= '0;
                noact_q <= '0;
            end
            if (bus.vs_uir) begin
                ir_q <= bus.ir_in;
            end
            // The channel is frozen at acceptance so a later IR update cannot move the request.
            if (accept) begin
                state   <= PEND;
                jdo_q   <= sr;
                act_q   <= sr[ACT_BIT] ? sel : '0;
                noact_q <= sr[ACT_BIT] ? '0 : sel;
            end
            if (do_cap) begin
                sr  <= bus.cap_data[ir_q*DR_W +: DR_W];
                cnt <= '0;
            end
            if (do_shift) begin
                sr <= {bus.tdi, sr[DR_W-1:1]};
                if (cnt != CW'(DR_W)) begin
                    cnt <= cnt + CW'(1);
                end
            end
            ovr_q   <= drop | (ovr_q & ~bus.clr_err);
            short_q <= (accept && (cnt != CW'(DR_W))) | (short_q & ~bus.clr_err);
        end
    end

    assign bus.tdo            = sr[0];
    assign bus.ir_out         = ir_q;
    assign bus.jdo            = jdo_q;
    assign bus.take_action    = act_q;
    assign bus.take_no_action = noact_q;
    assign bus.busy           = (state == PEND);
    assign bus.overrun        = ovr_q;
    assign bus.short_scan     = short_q;
endmodule

// File: tb/tb_debug_scan_slave_mc.sv
// Bench for debug_scan_slave_mc: directed scenarios plus randomized strobes against a
// queue-based reference model of the scan slave.
module tb_debug_scan_slave_mc;
    localparam int IR_W = 2;
    localparam int DR_W = 38;
    localparam int NCH  = 4;

    logic clk;
    logic reset;

    debug_scan_slave_mc_if #(.IR_W(IR_W), .DR_W(DR_W)) bus ();

    debug_scan_slave_mc #(.IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(DR_W-1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: scan register as a bit queue, element 0 is the bit on tdo.
    bit              sr_q[$];
    int              m_cnt;
    bit              m_pend;
    bit              m_act;
    int              m_ch;
    logic [IR_W-1:0] m_ir;
    logic [DR_W-1:0] m_jdo;
    bit              m_ovr;
    bit              m_short;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DR_W-1:0] q_word();
        logic [DR_W-1:0] w;
        for (int i = 0; i < DR_W; i++) w[i] = sr_q[i];
        return w;
    endfunction

    function automatic void q_load(input logic [DR_W-1:0] w);
        sr_q.delete();
        for (int i = 0; i < DR_W; i++) sr_q.push_back(w[i]);
    endfunction

    function automatic void model_reset();
        q_load('0);
        m_cnt = 0; m_pend = 0; m_act = 0; m_ch = 0; m_ir = '0;
        m_jdo = '0; m_ovr = 0; m_short = 0;
    endfunction

    function automatic void model_step();
        bit ovr_ev = 0;
        bit short_ev = 0;
        if (m_pend && bus.ack) m_pend = 0;
        if (bus.vs_uir) begin
            m_ir = bus.ir_in;
        end else if (bus.vs_udr) begin
            if (!m_pend) begin
                m_jdo    = q_word();
                m_pend   = 1;
                m_act    = sr_q[DR_W-1];
                m_ch     = int'(m_ir);
                short_ev = (m_cnt != DR_W);
            end else begin
                ovr_ev = 1;
            end
        end else if (bus.vs_cdr) begin
            q_load(bus.cap_data[int'(m_ir)*DR_W +: DR_W]);
            m_cnt = 0;
        end else if (bus.vs_sdr && bus.shift_en) begin
            void'(sr_q.pop_front());
            sr_q.push_back(bus.tdi);
            if (m_cnt < DR_W) m_cnt++;
        end
        if (bus.clr_err) begin m_ovr = 0; m_short = 0; end
        if (ovr_ev) m_ovr = 1;
        if (short_ev) m_short = 1;
    endfunction

    task automatic check_all(input string tag);
        logic [NCH-1:0] e_act, e_noact;
        e_act   = (m_pend && m_act)  ? NCH'(1 << m_ch) : '0;
        e_noact = (m_pend && !m_act) ? NCH'(1 << m_ch) : '0;
        check_eq({tag, ".tdo"},        64'(bus.tdo),            64'(sr_q[0]));
        check_eq({tag, ".ir_out"},     64'(bus.ir_out),         64'(m_ir));
        check_eq({tag, ".jdo"},        64'(bus.jdo),            64'(m_jdo));
        check_eq({tag, ".take_act"},   64'(bus.take_action),    64'(e_act));
        check_eq({tag, ".take_noact"}, 64'(bus.take_no_action), 64'(e_noact));
        check_eq({tag, ".busy"},       64'(bus.busy),           64'(m_pend));
        check_eq({tag, ".overrun"},    64'(bus.overrun),        64'(m_ovr));
        check_eq({tag, ".short_scan"}, 64'(bus.short_scan),     64'(m_short));
    endtask

    task automatic clear_strobes();
        bus.vs_uir = 0; bus.vs_cdr = 0; bus.vs_udr = 0; bus.vs_sdr = 0;
        bus.shift_en = 0; bus.ack = 0; bus.clr_err = 0; bus.tdi = 0;
    endtask

    // Inputs are set away from the edge; the model and DUT both see them at the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        clear_strobes();
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    task automatic shift_word(input logic [DR_W-1:0] w, input int nbits, input string tag);
        for (int i = 0; i < nbits; i++) begin
            bus.vs_sdr = 1; bus.shift_en = 1; bus.tdi = w[i];
            tick(tag);
        end
    endtask

    logic [DR_W-1:0] w1, w2, wcap;

    initial begin
        reset = 1'b1;
        bus.ir_in = '0;
        bus.cap_data = '0;
        clear_strobes();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Full scan on channel 2 with action bit set.
        w1 = {1'b1, 29'($urandom), 8'h5A};
        bus.ir_in = 2'd2; bus.vs_uir = 1; tick("uir");
        bus.vs_cdr = 1; tick("cdr");
        shift_word(w1, DR_W, "shift1");
        bus.vs_udr = 1; tick("udr1");
        check_eq("udr1.jdo_lo", 64'(bus.jdo[7:0]), 64'h5A);
        check_eq("udr1.ta_ch2", 64'(bus.take_action), 64'b0100);
        check_eq("udr1.busy1", 64'(bus.busy), 64'd1);
        bus.ack = 1; tick("ack1");
        check_eq("ack1.ta_zero", 64'(bus.take_action), 64'd0);

        // Capture word read back on tdo, LSB first.
        wcap = 38'h1_2345_6789;
        bus.cap_data = '0;
        bus.cap_data[2*DR_W +: DR_W] = wcap;
        bus.vs_cdr = 1; tick("cdr2");
        for (int i = 0; i < DR_W; i++) begin
            check_eq("tdo_seq", 64'(bus.tdo), 64'(wcap[i]));
            bus.vs_sdr = 1; bus.shift_en = 1; bus.tdi = 1'b0;
            tick("shift2");
        end

        // Overrun on a second update while pending, then clear.
        w2 = 38'h0A_BCDE_F012;
        bus.vs_cdr = 1; tick("cdr3");
        shift_word(w2, DR_W, "shift3");
        bus.vs_udr = 1; tick("udr3");
        bus.vs_udr = 1; tick("udr3b");
        check_eq("ovr.set", 64'(bus.overrun), 64'd1);
        check_eq("ovr.jdo_kept", 64'(bus.jdo), 64'(w2));
        bus.clr_err = 1; tick("clr");
        check_eq("ovr.cleared", 64'(bus.overrun), 64'd0);

        // Update together with ack replaces the pending word.
        bus.vs_cdr = 1; tick("cdr4");
        bus.vs_udr = 1; bus.ack = 1; tick("udr_ack");
        check_eq("udr_ack.jdo", 64'(bus.jdo), 64'(wcap));
        check_eq("udr_ack.busy", 64'(bus.busy), 64'd1);
        check_eq("udr_ack.ovr", 64'(bus.overrun), 64'd0);
        bus.ack = 1; bus.clr_err = 1; tick("ack4");

        // Short scan with action bit clear, then IR change while pending.
        bus.vs_cdr = 1; tick("cdr5");
        shift_word(38'h0_0005_5555, 20, "shift5");
        bus.vs_udr = 1; tick("udr5");
        check_eq("short.tna", 64'(bus.take_no_action), 64'b0100);
        check_eq("short.flag", 64'(bus.short_scan), 64'd1);
        bus.ir_in = 2'd1; bus.vs_uir = 1; tick("uir_pend");
        check_eq("uir_pend.tna", 64'(bus.take_no_action), 64'b0100);

        // Reset while pending must clear outputs before the next edge.
        @(negedge clk);
        async_reset("rst_pend");
        check_eq("rst_pend.busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 4; i++) tick("post_rst");

        // Randomized strobes.
        for (int n = 0; n < 1500; n++) begin
            bus.ir_in    = IR_W'($urandom_range(0, NCH-1));
            bus.vs_uir   = ($urandom_range(0, 15) == 0);
            bus.vs_udr   = ($urandom_range(0, 9) == 0);
            bus.vs_cdr   = ($urandom_range(0, 9) == 0);
            bus.vs_sdr   = ($urandom_range(0, 3) != 0);
            bus.shift_en = ($urandom_range(0, 3) != 0);
            bus.tdi      = 1'($urandom_range(0, 1));
            bus.ack      = ($urandom_range(0, 5) == 0);
            bus.clr_err  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < NCH*DR_W; k += 32) bus.cap_data[k +: 32] = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                clear_strobes();
                async_reset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_scan_slave_mc.md
DEBUG_SCAN_SLAVE_MC -- requirements
Module: debug_scan_slave_mc

Interface
REQ-001 SHALL have parameter IR_W, default 2, instruction register width; channel count NCH = 2**IR_W.
REQ-002 SHALL have parameter DR_W, default 38, data scan register width (at least 2).
REQ-003 SHALL have parameter ACT_BIT, default DR_W-1, index of the jdo bit selecting action vs no-action.
REQ-004 SHALL have one clock and asynchronous active-high reset, exactly as follows: clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ir_in  input  IR_W  instruction value, sampled on vs_uir.
REQ-007 vs_uir, vs_cdr, vs_udr  input  1 each  single-cycle update-IR, capture-DR and update-DR strobes, already synchronised to clk.
REQ-008 vs_sdr  input  1  shift-DR state; shift_en  input  1  one-bit shift qualifier.
REQ-009 tdi  input  1  serial data in; tdo  output  1  serial data out.
REQ-010 cap_data  input  NCH*DR_W  capture words, channel k at bits [k*DR_W +: DR_W].
REQ-011 ack  input  1  consumer acknowledges the pending action.
REQ-012 clr_err  input  1  clears the sticky error flags.
REQ-013 ir_out  output  IR_W  latched instruction.
REQ-014 jdo  output  DR_W  last accepted update word.
REQ-015 take_action, take_no_action  output  NCH each  one-hot per-channel request, held until ack.
REQ-016 busy  output  1  action pending.
REQ-017 overrun, short_scan  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and PEND; busy SHALL be 1 only in PEND.
REQ-019 SHALL load ir_q from ir_in on vs_uir; ir_out SHALL equal ir_q.
REQ-020 SHALL load sr from the cap_data slice selected by ir_q on vs_cdr, and SHALL clear the shift counter to 0 on the same edge.
REQ-021 SHALL shift sr <= {tdi, sr[DR_W-1:1]} on each cycle with vs_sdr & shift_en, and SHALL increment the shift counter, saturating at DR_W.
REQ-022 SHALL drive tdo = sr[0] combinationally.
REQ-023 SHALL accept vs_udr in IDLE, or in PEND when ack is high in the same cycle (ack is processed first).
REQ-024 On acceptance, jdo <= sr, the FSM enters PEND, and the next cycle SHALL assert bit ir_q of take_action if sr[ACT_BIT]=1, otherwise of take_no_action; at most one bit across both vectors SHALL be high.
REQ-025 Latency SHALL be exactly 1 cycle from the vs_udr edge to jdo and the request being valid.
REQ-026 In PEND, ack SHALL drop all request bits on the next edge and return the FSM to IDLE.
REQ-027 ack in IDLE SHALL have no effect.
REQ-028 vs_udr not accepted in PEND SHALL be dropped: jdo and the request stay unchanged, and overrun is set to 1.
REQ-029 An accepted vs_udr with shift counter != DR_W SHALL still be accepted and SHALL set short_scan to 1.
REQ-030 Simultaneous strobes SHALL follow priority vs_uir > vs_udr > vs_cdr > shift; lower-priority strobes in that cycle are ignored.
REQ-031 A capture or shift in PEND SHALL proceed normally and SHALL NOT alter jdo or the request.
REQ-032 clr_err SHALL clear overrun and short_scan; if an error event occurs in the same cycle, set SHALL win.
REQ-033 An ir_q change in PEND SHALL NOT move the asserted request bit.

Reset
REQ-034 On reset assertion, SHALL immediately force: FSM=IDLE, ir_q=0, sr=0, counter=0, jdo=0, take_action=0, take_no_action=0, busy=0, overrun=0, short_scan=0, tdo=0.
REQ-035 Reset mid-shift or in PEND SHALL abandon the operation; no request SHALL appear after deassertion.

Verification (IR_W=2, DR_W=38)
REQ-036 uir ir_in=2; cdr; 38 shifts of tdi pattern with bit37=1, low bits 0x5A; udr -> next cycle jdo[7:0]=0x5A, take_action=4'b0100, busy=1; ack -> take_action=0, busy=0.
REQ-037 cdr with cap_data channel 2 = 38'h1_2345_6789 -> tdo sequence over 38 shifts equals that word LSB first.
REQ-038 A second udr during PEND without ack -> overrun=1, jdo unchanged; clr_err -> overrun=0.
REQ-039 udr together with ack in PEND -> new jdo accepted, busy remains 1, overrun=0.
REQ-040 20 shifts then udr with bit37=0 -> take_no_action=4'b0100, short_scan=1.
REQ-041 Assert reset in PEND -> all outputs 0 asynchronously, before the next clk edge.
